// File: rtl/uart_report_pkg.sv
// Shared types and constants for the UART report formatter.
// Frame length depends on whether REPORT_CHECKSUM_EN is defined.
package uart_report_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV    = 3'd1,
    LOAD    = 3'd2,
    SEND    = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int unsigned FRAME_LEN_BASE = 32'd13;
  localparam int unsigned FRAME_LEN_CHK  = 32'd16;

  // Double-dabble correction: a BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [3:0] dabble(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO | {4'h0, d};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble).
// The first shift happens on the start edge, so done pulses 8 edges after start.
module bin2bcd8
  import uart_report_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_bin,
  output logic       o_done,
  output logic [3:0] o_hund,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [11:0] bcd_r;
  logic [7:0]  bin_r;
  logic [2:0]  cnt_r;
  logic        run_r;
  logic [11:0] adj_s;

  // Per-digit correction applied before each shift.
  always_comb begin
    adj_s = {dabble(bcd_r[11:8]), dabble(bcd_r[7:4]), dabble(bcd_r[3:0])};
  end

  // Shift engine: load performs iteration 1, seven more follow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_r  <= 12'd0;
      bin_r  <= 8'd0;
      cnt_r  <= 3'd0;
      run_r  <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        bcd_r <= {11'd0, i_bin[7]};
        bin_r <= {i_bin[6:0], 1'b0};
        cnt_r <= 3'd1;
        run_r <= 1'b1;
      end else if (run_r) begin
        {bcd_r, bin_r} <= {adj_s[10:0], bin_r, 1'b0};
        cnt_r          <= cnt_r + 3'd1;
        if (cnt_r == 3'd7) begin
          run_r  <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

  assign o_hund = bcd_r[11:8];
  assign o_tens = bcd_r[7:4];
  assign o_ones = bcd_r[3:0];

endmodule

// File: rtl/uart_report_fmt.sv
// Formats "T=ddd,H=ddd\r\n" and streams it through a UART TX start/busy handshake.
// Define REPORT_CHECKSUM_EN to append "*XX" (hex XOR of bytes 0..10) before CR/LF.
module uart_report_fmt
  import uart_report_pkg::*;
#(
  parameter logic [7:0] TEMP_TAG = 8'h54,
  parameter logic [7:0] HUM_TAG  = 8'h48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_trigger,
  input  logic [7:0] i_temp,
  input  logic [7:0] i_hum,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_busy,
  output logic       o_drop
);

`ifdef REPORT_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN_CHK - 32'd1);
`else
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN_BASE - 32'd1);
`endif

  state_t      state_r;
  logic [7:0]  temp_r;
  logic [7:0]  hum_r;
  logic        conv_start_r;
  logic [3:0]  idx_r;
  logic [3:0]  t_hund_r, t_tens_r, t_ones_r;
  logic [3:0]  h_hund_r, h_tens_r, h_ones_r;
  logic        t_done_s, h_done_s;
  logic [3:0]  t_hund_s, t_tens_s, t_ones_s;
  logic [3:0]  h_hund_s, h_tens_s, h_ones_s;
  logic [7:0]  byte_s;

  bin2bcd8 u_temp_conv (
    .clk    (clk),
    .reset  (reset),
    .i_start(conv_start_r),
    .i_bin  (temp_r),
    .o_done (t_done_s),
    .o_hund (t_hund_s),
    .o_tens (t_tens_s),
    .o_ones (t_ones_s)
  );

  bin2bcd8 u_hum_conv (
    .clk    (clk),
    .reset  (reset),
    .i_start(conv_start_r),
    .i_bin  (hum_r),
    .o_done (h_done_s),
    .o_hund (h_hund_s),
    .o_tens (h_tens_s),
    .o_ones (h_ones_s)
  );

`ifdef REPORT_CHECKSUM_EN
  logic [7:0] chk_s;

  // XOR over the printable body; constant bytes fold away in synthesis.
  always_comb begin
    chk_s = TEMP_TAG ^ ASCII_EQ ^ digit_char(t_hund_r) ^ digit_char(t_tens_r) ^
            digit_char(t_ones_r) ^ ASCII_COMMA ^ HUM_TAG ^ ASCII_EQ ^
            digit_char(h_hund_r) ^ digit_char(h_tens_r) ^ digit_char(h_ones_r);
  end
`endif

  // Byte map for the current frame index.
  always_comb begin
    byte_s = 8'h00;
    case (idx_r)
      4'd0:    byte_s = TEMP_TAG;
      4'd1:    byte_s = ASCII_EQ;
      4'd2:    byte_s = digit_char(t_hund_r);
      4'd3:    byte_s = digit_char(t_tens_r);
      4'd4:    byte_s = digit_char(t_ones_r);
      4'd5:    byte_s = ASCII_COMMA;
      4'd6:    byte_s = HUM_TAG;
      4'd7:    byte_s = ASCII_EQ;
      4'd8:    byte_s = digit_char(h_hund_r);
      4'd9:    byte_s = digit_char(h_tens_r);
      4'd10:   byte_s = digit_char(h_ones_r);
`ifdef REPORT_CHECKSUM_EN
      4'd11:   byte_s = ASCII_STAR;
      4'd12:   byte_s = hex_char(chk_s[7:4]);
      4'd13:   byte_s = hex_char(chk_s[3:0]);
      4'd14:   byte_s = ASCII_CR;
      4'd15:   byte_s = ASCII_LF;
`else
      4'd11:   byte_s = ASCII_CR;
      4'd12:   byte_s = ASCII_LF;
`endif
      default: byte_s = 8'h00;
    endcase
  end

  // Frame sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      temp_r       <= 8'd0;
      hum_r        <= 8'd0;
      conv_start_r <= 1'b0;
      idx_r        <= 4'd0;
      t_hund_r     <= 4'd0;
      t_tens_r     <= 4'd0;
      t_ones_r     <= 4'd0;
      h_hund_r     <= 4'd0;
      h_tens_r     <= 4'd0;
      h_ones_r     <= 4'd0;
      o_tx_data    <= 8'h00;
      o_tx_start   <= 1'b0;
      o_busy       <= 1'b0;
      o_drop       <= 1'b0;
    end else begin
      conv_start_r <= 1'b0;
      o_tx_start   <= 1'b0;
      o_drop       <= i_trigger && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (i_trigger) begin
            temp_r       <= i_temp;
            hum_r        <= i_hum;
            conv_start_r <= 1'b1;
            o_busy       <= 1'b1;
            state_r      <= CONV;
          end
        end
        CONV: begin
          // Both converters start together and have fixed latency.
          if (t_done_s && h_done_s) begin
            t_hund_r <= t_hund_s;
            t_tens_r <= t_tens_s;
            t_ones_r <= t_ones_s;
            h_hund_r <= h_hund_s;
            h_tens_r <= h_tens_s;
            h_ones_r <= h_ones_s;
            idx_r    <= 4'd0;
            state_r  <= LOAD;
          end
        end
        LOAD: begin
          o_tx_data <= byte_s;
          state_r   <= SEND;
        end
        SEND: begin
          if (!i_tx_busy) begin
            o_tx_start <= 1'b1;
            state_r    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (i_tx_busy) begin
            state_r <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!i_tx_busy) begin
            if (idx_r == LAST_IDX) begin
              o_busy  <= 1'b0;
              state_r <= IDLE;
            end else begin
              idx_r   <= idx_r + 4'd1;
              state_r <= LOAD;
            end
          end
        end
        default: begin
          o_busy  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_report_fmt.sv
// Self-checking bench for uart_report_fmt against a string-based frame model.
// Honors REPORT_CHECKSUM_EN so the same bench covers both builds.
module tb_uart_report_fmt;

`ifdef REPORT_CHECKSUM_EN
  localparam int FLEN = 16;
`else
  localparam int FLEN = 13;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_trigger = 1'b0;
  logic [7:0] i_temp = 8'd0;
  logic [7:0] i_hum = 8'd0;
  logic       i_tx_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_drop;

  int checks = 0;
  int errors = 0;
  int byte_cycles = 20;
  bit init_phase = 1'b1;
  int bcnt;
  int cyc;
  int drops, viol, gap_err, stab_err, trig_cyc, fall_cyc;
  bit lat_armed, have_fall, prev_busy;
  logic [7:0] cur_byte;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int lat_q[$];

  uart_report_fmt dut (
    .clk       (clk),
    .reset     (reset),
    .i_trigger (i_trigger),
    .i_temp    (i_temp),
    .i_hum     (i_hum),
    .i_tx_busy (i_tx_busy),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .o_busy    (o_busy),
    .o_drop    (o_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises the cycle after start and lasts byte_cycles cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) bcnt <= 0;
    else if (o_tx_start) bcnt <= byte_cycles;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign i_tx_busy = (bcnt != 0);

  // Monitor: collects sent bytes and handshake timing on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      lat_armed <= 1'b0;
      have_fall <= 1'b0;
      prev_busy <= 1'b0;
      if (init_phase) begin
        drops <= 0; viol <= 0; gap_err <= 0; stab_err <= 0; trig_cyc <= 0; fall_cyc <= 0;
        cur_byte <= 8'h00;
      end
    end else begin
      if (o_drop) drops <= drops + 1;
      if (i_trigger && !o_busy) begin
        trig_cyc  <= cyc;
        lat_armed <= 1'b1;
        have_fall <= 1'b0;
      end else if (prev_busy && !i_tx_busy) begin
        fall_cyc  <= cyc;
        have_fall <= 1'b1;
      end
      if (o_tx_start) begin
        rx_q.push_back(o_tx_data);
        cur_byte <= o_tx_data;
        if (i_tx_busy) viol <= viol + 1;
        if (lat_armed) begin
          lat_q.push_back(cyc - trig_cyc - 1);
          lat_armed <= 1'b0;
        end
        if (have_fall && (cyc - fall_cyc != 3)) gap_err <= gap_err + 1;
        have_fall <= 1'b0;
      end
      if (i_tx_busy && prev_busy && (o_tx_data !== cur_byte)) stab_err <= stab_err + 1;
      prev_busy <= i_tx_busy;
    end
  end

  task automatic make_expected(input int t, input int h);
    string s;
    logic [7:0] x;
    s = $sformatf("T=%03d,H=%03d", t, h);
    exp_q.delete();
    x = 8'h00;
    for (int i = 0; i < s.len(); i++) begin
      exp_q.push_back(s[i]);
      x = x ^ s[i];
    end
`ifdef REPORT_CHECKSUM_EN
    s = $sformatf("*%02X", x);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_trigger(input logic [7:0] t, input logic [7:0] h);
    @(posedge clk); #1;
    i_temp = t; i_hum = h; i_trigger = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!o_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h, required 00", o_tx_data); end
    checks++; if ({o_tx_start, o_busy, o_drop} !== 3'b000) begin errors++; $display("FAIL rst_flags: start/busy/drop=%b, required 000", {o_tx_start, o_busy, o_drop}); end
    @(posedge clk); #1; reset = 1'b1; init_phase = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b, required 0", o_busy); end
  endtask

  task automatic test_basic;
    bit ok;
    rx_q.delete();
    make_expected(25, 60);
    pulse_trigger(8'd25, 8'd60);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: o_busy=%b, required 0", o_busy); end
    checks++; if (i_tx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_order: tx_busy=%b when o_busy fell, required 0", i_tx_busy); end
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL basic_len: got %0d starts, required %0d", rx_q.size(), FLEN); end
    for (int i = 0; i < FLEN && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d: got %02h, required %02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_boundary;
    bit ok;
    int t, h;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin t = 0; h = 255; end
      else if (k == 1) begin t = 255; h = 0; end
      else begin t = $urandom_range(0, 255); h = $urandom_range(0, 255); byte_cycles = $urandom_range(1, 20); end
      rx_q.delete();
      make_expected(t, h);
      pulse_trigger(t[7:0], h[7:0]);
      wait_idle(2000, ok);
      checks++; if (!ok || rx_q.size() != FLEN) begin errors++; $display("FAIL conv_len t=%0d h=%0d: done=%b starts=%0d, required 1/%0d", t, h, ok, rx_q.size(), FLEN); end
      for (int i = 0; i < FLEN && i < rx_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL conv_byte%0d t=%0d h=%0d: got %02h, required %02h", i, t, h, rx_q[i], exp_q[i]); end
      end
    end
    byte_cycles = 20;
  endtask

  task automatic test_drop;
    bit ok;
    int d0;
    rx_q.delete();
    make_expected(25, 60);
    d0 = drops;
    pulse_trigger(8'd25, 8'd60);
    repeat (48) @(posedge clk);
    #1; i_temp = 8'd200; i_hum = 8'd1; i_trigger = 1'b1;
    @(posedge clk); #1; i_trigger = 1'b0;
    wait_idle(2000, ok);
    repeat (3) @(negedge clk);
    checks++; if (drops - d0 != 1) begin errors++; $display("FAIL drop_count: got %0d pulses, required 1", drops - d0); end
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL drop_len: got %0d, required %0d", rx_q.size(), FLEN); end
    for (int i = 0; i < FLEN && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_byte%0d: got %02h, required %02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_snapshot;
    bit ok;
    rx_q.delete();
    make_expected(25, 60);
    pulse_trigger(8'd25, 8'd60);
    i_temp = 8'd99; i_hum = 8'd3;
    wait_idle(2000, ok);
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL snap_len: got %0d, required %0d", rx_q.size(), FLEN); end
    for (int i = 0; i < FLEN && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL snap_byte%0d: got %02h, required %02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    rx_q.delete();
    pulse_trigger(8'd25, 8'd60);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 6) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach_byte5: got %0d starts, required 6", rx_q.size()); end
    repeat (4) @(posedge clk);
    #2; reset = 1'b0; #1;
    checks++; if ({o_tx_data, o_tx_start, o_busy, o_drop} !== 11'd0) begin errors++; $display("FAIL mid_async_clear: data=%02h start/busy/drop=%b, required 00/000", o_tx_data, {o_tx_start, o_busy, o_drop}); end
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    rx_q.delete();
    repeat (40) @(negedge clk);
    checks++; if (rx_q.size() != 0 || o_busy !== 1'b0) begin errors++; $display("FAIL mid_no_resume: starts=%0d busy=%b, required 0/0", rx_q.size(), o_busy); end
    make_expected(7, 128);
    pulse_trigger(8'd7, 8'd128);
    wait_idle(2000, ok);
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL mid_new_len: got %0d, required %0d", rx_q.size(), FLEN); end
    for (int i = 0; i < FLEN && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_new_byte%0d: got %02h, required %02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_protocol;
    checks++; if (viol != 0) begin errors++; $display("FAIL start_while_busy: got %0d, required 0", viol); end
    checks++; if (gap_err != 0) begin errors++; $display("FAIL inter_byte_gap: got %0d bad gaps, required 0", gap_err); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL data_stable: got %0d changes, required 0", stab_err); end
    checks++; if (lat_q.size() < 12) begin errors++; $display("FAIL latency_samples: got %0d, required >= 12", lat_q.size()); end
    for (int i = 0; i < lat_q.size(); i++) begin
      checks++; if (lat_q[i] > 12 || lat_q[i] < 1 || lat_q[i] != lat_q[0]) begin errors++; $display("FAIL latency%0d: got %0d, required constant %0d within 1..12", i, lat_q[i], lat_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_drop();
    test_snapshot();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_report_fmt.md
Name: uart_report_fmt

Overview:
- Upstream feeder for the byte-level UART transmitter. On a trigger pulse it snapshots one 8-bit temperature value and one 8-bit humidity value, and converts each to 3-digit ASCII decimal.
- It then streams the fixed-format frame "T=ddd,H=ddd\r\n" (13 bytes) one byte at a time through the transmitter's start/busy handshake.
- It sits between the sensor/control logic and the UART TX stage.

Parameters:
- TEMP_TAG, 8'h54 ("T"), ASCII tag byte preceding the temperature field.
- HUM_TAG, 8'h48 ("H"), ASCII tag byte preceding the humidity field.

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- i_trigger  input  1  1-cycle request to send one report
- i_temp  input  8  unsigned temperature, 0..255
- i_hum  input  8  unsigned humidity, 0..255
- i_tx_busy  input  1  busy flag from the UART transmitter
- o_tx_data  output  8  byte presented to the transmitter
- o_tx_start  output  1  1-cycle start pulse to the transmitter
- o_busy  output  1  high from trigger acceptance until the last byte completes
- o_drop  output  1  1-cycle pulse when a trigger arrives while o_busy is high

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; o_tx_data=8'h00; o_tx_start=0; o_busy=0; o_drop=0.
  - Byte index and snapshot registers are cleared.
  - Reset mid-frame aborts immediately. Nothing resumes after release.
- IDLE:
  - On i_trigger=1, latch i_temp and i_hum, start both converters, set o_busy=1, go to CONV.
  - i_trigger during any non-IDLE state is ignored for the frame and produces o_drop=1 on the next cycle.
- CONV:
  - Wait for both bin2bcd8 done flags. They are fixed at 8 cycles, running in parallel.
  - Latch the hundreds, tens and ones digits for each value. Go to LOAD with byte index=0.
- LOAD:
  - Drive o_tx_data = byte[index]. Go to SEND.
- Byte map:
  - 0 = TEMP_TAG, 1 = "=", 2..4 = temperature digits (8'h30+digit, hundreds first).
  - 5 = ",", 6 = HUM_TAG, 7 = "=", 8..10 = humidity digits.
  - 11 = 8'h0D, 12 = 8'h0A.
  - Leading zeros are always sent, e.g. 7 -> "007".
- SEND:
  - Only when i_tx_busy=0, assert o_tx_start for exactly one cycle. Go to WAIT_HI.
  - o_tx_data is stable from LOAD until the frame leaves WAIT_LO for that byte.
- WAIT_HI:
  - Wait for i_tx_busy=1. The transmitter raises busy on the cycle after start. Go to WAIT_LO.
- WAIT_LO:
  - Wait for i_tx_busy=0.
  - If index=last, go to IDLE and clear o_busy in the same edge.
  - Otherwise increment the index and go to LOAD.
- o_tx_start is never asserted while i_tx_busy=1 and is never asserted twice for one byte.
- Latency:
  - The first o_tx_start occurs a constant number of cycles after trigger acceptance, no more than 12.
  - Inter-byte gap: 3 cycles from busy falling to the next start.
- Trigger on the same cycle o_busy falls is not accepted. o_busy clears as the FSM enters IDLE, and the trigger must arrive while the FSM is in IDLE.
- Inputs i_temp and i_hum may change freely after the trigger. Only snapshot values are sent.

Optional Feature:
- Macro: REPORT_CHECKSUM_EN.
- Defined:
  - Insert "*" plus two uppercase ASCII hex chars of the XOR of bytes 0..10 before CR/LF.
  - Frame becomes 16 bytes, e.g. "T=025,H=060*XX\r\n".
- Undefined: 13-byte frame with no checksum logic present.

Decomposition:
- Package uart_report_pkg holds:
  - state encoding (IDLE, CONV, LOAD, SEND, WAIT_HI, WAIT_LO)
  - ASCII constants (EQ, COMMA, STAR, CR, LF, ZERO)
  - frame length constants for both builds
- Sub-module bin2bcd8:
  - 8-bit double-dabble converter, iterative over 8 cycles.
  - Ports: clk, reset, i_start, i_bin[7:0], o_done, o_hund[3:0], o_tens[3:0], o_ones[3:0].
  - Two instances.

Test Plan:
- Directed scenarios use a bench busy model of 20 cycles per byte, plus the real transmitter with CLKS_PER_BIT=4.
- i_temp=25, i_hum=60, trigger -> 13 bytes "T=025,H=060\r\n" (54 3D 30 32 35 2C 48 3D 30 36 30 0D 0A), one o_tx_start per byte, o_busy low after the last busy falls.
- i_temp=0, i_hum=255 -> digits "000" and "255". Boundary conversion is correct.
- Second trigger 50 cycles into a frame -> o_drop pulses once, and the frame content is unchanged.
- Change i_temp to 99 one cycle after trigger -> the frame still carries the snapshot value.
- reset=0 while byte 5 is in flight -> all outputs return to reset values immediately. A new trigger after release sends a full frame from byte 0.
- REPORT_CHECKSUM_EN with 25/60 -> 16-byte frame. Bytes 11..13 are "*" and the hex XOR of bytes 0..10, checked against a model.
